tap_shift_chain: RTL and testbench
==================================

Name: tap_shift_chain

Overview:
- Parametrised successor to the single-bit, fixed 15-stage serial-in/parallel-out chain.
- Multi-bit stages, configurable depth, bidirectional shift, rotate, parallel load, hold.
- Adds a registered serial output and fill tracking (count plus full flag).
- Sits between the input pad buffer and the output buffers; every stage drives a tap.

Parameters:
- WIDTH, 1, bits per stage (>=1)
- DEPTH, 15, number of stages (>=2)
- CNT_W, $clog2(DEPTH+1), fill_count width (derived; do not override)

Ports:
- newCLK  input  1  single clock; all state updates on the rising edge
- global_reset  input  1  asynchronous, active-high reset
- in1  input  WIDTH  serial data inserted on shift
- shift_en  input  1  qualifies mode; 0 = hold regardless of mode
- dir  input  1  0: stage k-1 -> k, insert at stage 0; 1: stage k+1 -> k, insert at stage DEPTH-1
- mode  input  2  00 hold, 01 shift, 10 rotate, 11 parallel load
- load_data  input  DEPTH*WIDTH  parallel load value; slice k = stage k
- out  output  DEPTH*WIDTH  taps; slice k = stage k (out1 of the legacy naming = stage 0)
- serial_out  output  WIDTH  registered copy of the stage dropped by the last shift
- fill_count  output  CNT_W  number of valid stages filled since reset or load, saturating at DEPTH
- full  output  1  fill_count == DEPTH

Behaviour:
- Reset:
  - global_reset=1 asynchronously clears all stages, serial_out, fill_count and full to 0, with no clock edge needed.
  - State stays cleared while reset is asserted.
  - Operation resumes on the first rising edge after deassertion.
- Hold (shift_en=0, or mode=00): all state keeps its value.
- Shift (shift_en=1, mode=01):
  - dir=0: stage0<=in1; stage k<=stage k-1; serial_out<=old stage DEPTH-1.
  - dir=1: stage DEPTH-1<=in1; stage k<=stage k+1; serial_out<=old stage 0.
  - fill_count<=min(fill_count+1, DEPTH).
- Rotate (shift_en=1, mode=10):
  - Same movement as shift, but the dropped stage wraps into the insert end instead of in1.
  - serial_out<=dropped stage. fill_count unchanged.
- Parallel load (shift_en=1, mode=11):
  - All stages <= load_data.
  - fill_count<=DEPTH. serial_out unchanged.
- Latency:
  - in1 sampled at edge N appears on the insert-end tap after edge N.
  - It reaches the far tap after DEPTH shifts.
  - It appears on serial_out at shift DEPTH+1.
- full is combinational from fill_count, with no extra cycle.
- Direction change between consecutive shifts is legal and takes effect on that edge; fill_count still increments.
- Saturation: shifts while full keep fill_count=DEPTH; no wrap to 0.
- in1, dir, mode and load_data are ignored when the operation does not use them.

Test Plan:
- Async reset: DEPTH=15, WIDTH=1. Load 0x7FFF, then assert global_reset between edges. Required: out=0x0000, serial_out=0, fill_count=0, full=0 immediately; state stays 0 across edges while asserted.
- Walking one: from reset, dir=0, mode=01, shift_en=1, in1=1 for one cycle then 0.
  - After shift k, only bit k-1 of out is set.
  - full=1 after the 15th shift.
  - serial_out=1 after the 16th shift; out=0x0000.
- Hold: after 7 shifts of in1=1, drive shift_en=0 (mode=01) for 5 cycles, then shift_en=1, mode=00 for 3 cycles. Required: out=0x007F and fill_count=7 throughout.
- Rotate:
  - Load 0x0001, then rotate dir=0 for 15 cycles. Required: out=0x0001, fill_count=15, serial_out=1 after the 15th rotate.
  - One rotate with dir=1. Required: out=0x4000.
- Parallel load: load 0x5A5A. Required: out=0x5A5A next edge, fill_count=15, full=1.
  - Repeat with global_reset asserted in the same cycle. Required: reset wins, out=0.
- Wide/short config: WIDTH=4, DEPTH=8, dir=1, shift in1=1..8 over 8 shifts. Required: stage0=1, stage7=8, full=1.
  - A 9th shift with in1=0xF. Required: serial_out=1, stage7=0xF, fill_count stays 8.

Source files
------------

// File: rtl/tap_shift_chain.sv
// -----------------------------------------------------------------------------
// tap_shift_chain
//
// Multi-bit, configurable-depth shift chain with one tap per stage. It can
// shift in either direction, rotate, take a parallel load or hold. It also
// keeps a registered copy of the stage dropped by the last move, plus a
// saturating count of how many stages have been filled.
//
// Ports
//   newCLK        in   1            rising-edge clock for all state
//   global_reset  in   1            asynchronous, active-high clear of all state
//   in1           in   WIDTH        serial data inserted on a shift
//   shift_en      in   1            0 forces hold whatever the mode is
//   dir           in   1            0: k-1 -> k, insert at stage 0
//                                   1: k+1 -> k, insert at stage DEPTH-1
//   mode          in   2            00 hold, 01 shift, 10 rotate, 11 load
//   load_data     in   DEPTH*WIDTH  parallel load value, slice k = stage k
//   out           out  DEPTH*WIDTH  stage taps, slice k = stage k
//   serial_out    out  WIDTH        stage dropped by the last shift/rotate
//   fill_count    out  CNT_W        stages filled since reset/load, saturating
//   full          out  1            fill_count == DEPTH
// -----------------------------------------------------------------------------
module tap_shift_chain #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 15,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                   newCLK,
    input  logic                   global_reset,
    input  logic [WIDTH-1:0]       in1,
    input  logic                   shift_en,
    input  logic                   dir,
    input  logic [1:0]             mode,
    input  logic [DEPTH*WIDTH-1:0] load_data,
    output logic [DEPTH*WIDTH-1:0] out,
    output logic [WIDTH-1:0]       serial_out,
    output logic [CNT_W-1:0]       fill_count,
    output logic                   full
);

    localparam logic [1:0] MODE_SHIFT  = 2'b01;
    localparam logic [1:0] MODE_ROTATE = 2'b10;
    localparam logic [1:0] MODE_LOAD   = 2'b11;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Stages are kept packed so that one register process owns the whole
    // chain while each stage's next value is built by its own assign.
    logic [DEPTH*WIDTH-1:0] stage_q;
    logic [DEPTH*WIDTH-1:0] stage_d;
    logic [WIDTH-1:0]       serial_q;
    logic [WIDTH-1:0]       serial_d;
    logic [CNT_W-1:0]       fill_q;
    logic [CNT_W-1:0]       fill_d;

    logic                   do_shift;
    logic                   do_rotate;
    logic                   do_load;
    logic                   do_move;
    logic [WIDTH-1:0]       dropped;
    logic [WIDTH-1:0]       insert_val;

    assign do_shift  = shift_en && (mode == MODE_SHIFT);
    assign do_rotate = shift_en && (mode == MODE_ROTATE);
    assign do_load   = shift_en && (mode == MODE_LOAD);
    assign do_move   = do_shift || do_rotate;

    // The stage leaving the chain is at the end opposite the insert end.
    assign dropped    = dir ? stage_q[0 +: WIDTH] : stage_q[(DEPTH-1)*WIDTH +: WIDTH];
    // A rotate feeds the dropped stage back in place of the serial input.
    assign insert_val = do_rotate ? dropped : in1;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] from_lo;
            logic [WIDTH-1:0] from_hi;

            if (gi == 0) begin : g_lo_end
                assign from_lo = insert_val;
            end else begin : g_lo_mid
                assign from_lo = stage_q[(gi-1)*WIDTH +: WIDTH];
            end

            if (gi == DEPTH - 1) begin : g_hi_end
                assign from_hi = insert_val;
            end else begin : g_hi_mid
                assign from_hi = stage_q[(gi+1)*WIDTH +: WIDTH];
            end

            assign stage_d[gi*WIDTH +: WIDTH] =
                do_move ? (dir ? from_hi : from_lo) :
                do_load ? load_data[gi*WIDTH +: WIDTH] :
                          stage_q[gi*WIDTH +: WIDTH];

            assign out[gi*WIDTH +: WIDTH] = stage_q[gi*WIDTH +: WIDTH];
        end
    endgenerate

    always_comb begin
        fill_d   = fill_q;
        serial_d = serial_q;
        if (do_shift) begin
            serial_d = dropped;
            if (fill_q != FULL_CNT) begin
                fill_d = fill_q + CNT_W'(1);
            end
        end else if (do_rotate) begin
            // Rotation only rearranges data already present: no new fill.
            serial_d = dropped;
        end else if (do_load) begin
            // Load leaves serial_out alone; nothing was dropped.
            fill_d = FULL_CNT;
        end
    end

    always_ff @(posedge newCLK or posedge global_reset) begin
        if (global_reset) begin
            stage_q  <= '0;
            serial_q <= '0;
            fill_q   <= '0;
        end else begin
            stage_q  <= stage_d;
            serial_q <= serial_d;
            fill_q   <= fill_d;
        end
    end

    assign serial_out = serial_q;
    assign fill_count = fill_q;
    assign full       = (fill_q == FULL_CNT);

endmodule

// File: tb/tb_tap_shift_chain.sv
// -----------------------------------------------------------------------------
// tb_tap_shift_chain
//
// Drives two instances off one clock: the default 15x1 chain (dut_a), stepped
// through a table of directed vectors, and a 8x4 chain (dut_b) for the wide
// configuration. Hand-written sequences cover asynchronous reset and reset
// winning over a load.
// -----------------------------------------------------------------------------
module tb_tap_shift_chain;

    localparam logic [1:0] M_HOLD   = 2'b00;
    localparam logic [1:0] M_SHIFT  = 2'b01;
    localparam logic [1:0] M_ROTATE = 2'b10;
    localparam logic [1:0] M_LOAD   = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // dut_a: WIDTH=1, DEPTH=15
    logic        rst_a;
    logic        in1_a;
    logic        en_a;
    logic        dir_a;
    logic [1:0]  mode_a;
    logic [14:0] ld_a;
    logic [14:0] out_a;
    logic        ser_a;
    logic [3:0]  cnt_a;
    logic        full_a;

    // dut_b: WIDTH=4, DEPTH=8
    logic        rst_b;
    logic [3:0]  in1_b;
    logic        en_b;
    logic        dir_b;
    logic [1:0]  mode_b;
    logic [31:0] ld_b;
    logic [31:0] out_b;
    logic [3:0]  ser_b;
    logic [3:0]  cnt_b;
    logic        full_b;

    tap_shift_chain #(.WIDTH(1), .DEPTH(15)) dut_a (
        .newCLK       (clk),
        .global_reset (rst_a),
        .in1          (in1_a),
        .shift_en     (en_a),
        .dir          (dir_a),
        .mode         (mode_a),
        .load_data    (ld_a),
        .out          (out_a),
        .serial_out   (ser_a),
        .fill_count   (cnt_a),
        .full         (full_a)
    );

    tap_shift_chain #(.WIDTH(4), .DEPTH(8)) dut_b (
        .newCLK       (clk),
        .global_reset (rst_b),
        .in1          (in1_b),
        .shift_en     (en_b),
        .dir          (dir_b),
        .mode         (mode_b),
        .load_data    (ld_b),
        .out          (out_b),
        .serial_out   (ser_b),
        .fill_count   (cnt_b),
        .full         (full_b)
    );

    typedef struct {
        logic        rst;
        logic        en;
        logic        dir;
        logic [1:0]  mode;
        logic        in1;
        logic [14:0] ld;
        logic [14:0] e_out;
        logic        e_ser;
        logic [3:0]  e_cnt;
        logic        e_full;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void add(input logic rst, input logic en, input logic dir,
                                input logic [1:0] mode, input logic in1,
                                input logic [14:0] ld, input logic [14:0] e_out,
                                input logic e_ser, input logic [3:0] e_cnt,
                                input logic e_full);
        vec_t v;
        v.rst = rst; v.en = en; v.dir = dir; v.mode = mode; v.in1 = in1;
        v.ld = ld; v.e_out = e_out; v.e_ser = e_ser; v.e_cnt = e_cnt;
        v.e_full = e_full;
        tbl.push_back(v);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_a(input string tag, input logic [14:0] eo, input logic es,
                           input logic [3:0] ec, input logic ef);
        check({tag, " out"},        32'(out_a),  32'(eo));
        check({tag, " serial_out"}, 32'(ser_a),  32'(es));
        check({tag, " fill_count"}, 32'(cnt_a),  32'(ec));
        check({tag, " full"},       32'(full_a), 32'(ef));
    endtask

    // Step one rising edge and land 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a = 1'b1; in1_a = 1'b0; en_a = 1'b0; dir_a = 1'b0; mode_a = M_HOLD; ld_a = '0;
        rst_b = 1'b1; in1_b = '0;   en_b = 1'b0; dir_b = 1'b0; mode_b = M_HOLD; ld_b = '0;

        // ---------------- vector table for dut_a ----------------
        // walking one
        add(1, 0, 0, M_HOLD, 0, '0, '0, 0, 0, 0);
        for (int k = 1; k <= 15; k++)
            add(0, 1, 0, M_SHIFT, logic'(k == 1), '0, 15'(1 << (k - 1)), 0,
                4'(k), logic'(k == 15));
        add(0, 1, 0, M_SHIFT, 0, '0, '0, 1, 15, 1);

        // hold: 7 ones shifted in, then shift_en=0, then mode=00
        add(1, 0, 0, M_HOLD, 0, '0, '0, 0, 0, 0);
        for (int k = 1; k <= 7; k++)
            add(0, 1, 0, M_SHIFT, 1, '0, 15'((1 << k) - 1), 0, 4'(k), 0);
        for (int k = 0; k < 5; k++)
            add(0, 0, 1, M_SHIFT, 1, 15'h7FFF, 15'h007F, 0, 7, 0);
        for (int k = 0; k < 3; k++)
            add(0, 1, 1, M_HOLD, 1, 15'h7FFF, 15'h007F, 0, 7, 0);

        // rotate on a partly filled chain leaves fill_count alone
        add(1, 0, 0, M_HOLD, 0, '0, '0, 0, 0, 0);
        add(0, 1, 0, M_SHIFT, 1, '0, 15'h0001, 0, 1, 0);
        add(0, 1, 0, M_ROTATE, 0, '0, 15'h0002, 0, 1, 0);
        add(0, 1, 1, M_ROTATE, 0, '0, 15'h0001, 0, 1, 0);

        // load 1, rotate dir=0 a full turn (in1=1 must be ignored), then dir=1
        add(0, 1, 0, M_LOAD, 0, 15'h0001, 15'h0001, 0, 15, 1);
        for (int k = 1; k <= 15; k++)
            add(0, 1, 0, M_ROTATE, 1, '0, (k < 15) ? 15'(1 << k) : 15'h0001,
                logic'(k == 15), 15, 1);
        add(0, 1, 1, M_ROTATE, 1, '0, 15'h4000, 1, 15, 1);

        // parallel load, then direction change while saturated
        add(0, 1, 0, M_LOAD, 0, 15'h5A5A, 15'h5A5A, 1, 15, 1);
        add(0, 1, 0, M_SHIFT, 1, '0, 15'h34B5, 1, 15, 1);
        add(0, 1, 1, M_SHIFT, 0, '0, 15'h1A5A, 1, 15, 1);

        tick();
        tick();

        for (int i = 0; i < tbl.size(); i++) begin
            rst_a  = tbl[i].rst;
            en_a   = tbl[i].en;
            dir_a  = tbl[i].dir;
            mode_a = tbl[i].mode;
            in1_a  = tbl[i].in1;
            ld_a   = tbl[i].ld;
            tick();
            $display("vec %0d: out=0x%04h ser=%0d cnt=%0d full=%0d",
                     i, out_a, ser_a, cnt_a, full_a);
            check_a($sformatf("vec%0d", i), tbl[i].e_out, tbl[i].e_ser,
                    tbl[i].e_cnt, tbl[i].e_full);
        end

        // ---------------- asynchronous reset ----------------
        rst_a = 1'b0; en_a = 1'b1; mode_a = M_LOAD; ld_a = 15'h7FFF; dir_a = 1'b0;
        tick();
        $display("async load: out=0x%04h cnt=%0d", out_a, cnt_a);
        check_a("pre_reset", 15'h7FFF, 1'b1, 4'd15, 1'b1);
        #2;
        rst_a  = 1'b1;
        mode_a = M_SHIFT;
        in1_a  = 1'b1;
        #1;
        $display("async reset (no edge): out=0x%04h ser=%0d cnt=%0d", out_a, ser_a, cnt_a);
        check_a("async_reset", '0, 1'b0, 4'd0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            tick();
            $display("reset held %0d: out=0x%04h cnt=%0d", k, out_a, cnt_a);
            check_a($sformatf("reset_held%0d", k), '0, 1'b0, 4'd0, 1'b0);
        end

        // reset asserted during a load: reset wins
        mode_a = M_LOAD;
        ld_a   = 15'h5A5A;
        tick();
        $display("reset vs load: out=0x%04h cnt=%0d", out_a, cnt_a);
        check_a("reset_wins_load", '0, 1'b0, 4'd0, 1'b0);
        rst_a = 1'b0;
        tick();
        $display("load after release: out=0x%04h cnt=%0d", out_a, cnt_a);
        check_a("load_after_release", 15'h5A5A, 1'b0, 4'd15, 1'b1);

        // ---------------- wide/short config on dut_b ----------------
        rst_b = 1'b0; en_b = 1'b1; dir_b = 1'b1; mode_b = M_SHIFT;
        for (int k = 1; k <= 8; k++) begin
            in1_b = 4'(k);
            tick();
            $display("wide shift %0d: out=0x%08h ser=%0h cnt=%0d full=%0d",
                     k, out_b, ser_b, cnt_b, full_b);
            if (k == 1) begin
                check("wide first out", out_b, 32'h1000_0000);
                check("wide first cnt", 32'(cnt_b), 32'd1);
            end
        end
        check("wide stage0",  32'(out_b[3:0]),   32'h1);
        check("wide stage7",  32'(out_b[31:28]), 32'h8);
        check("wide out",     out_b,             32'h8765_4321);
        check("wide full",    32'(full_b),       32'd1);
        check("wide cnt",     32'(cnt_b),        32'd8);
        check("wide ser pre", 32'(ser_b),        32'h0);
        in1_b = 4'hF;
        tick();
        $display("wide shift 9: out=0x%08h ser=%0h cnt=%0d full=%0d",
                 out_b, ser_b, cnt_b, full_b);
        check("wide9 ser",    32'(ser_b),        32'h1);
        check("wide9 stage7", 32'(out_b[31:28]), 32'hF);
        check("wide9 out",    out_b,             32'hF876_5432);
        check("wide9 cnt",    32'(cnt_b),        32'd8);
        check("wide9 full",   32'(full_b),       32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
